// File: rtl/ex_branch_unit.sv
// Execute-stage branch resolution: evaluates branch conditions from ALU flags, requests a
// fetch redirect and squashes wrong-path work. Optional statistics under BRANCH_STATS_EN.
module ex_branch_unit #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [2:0]  funct3,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        zero,
    input  logic        slt,
    input  logic        sltu,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    output logic [31:0] link_pc,
    output logic        flush,
    output logic        illegal,
    output logic        misalign,
    output logic [31:0] branch_cnt,
    output logic [31:0] taken_cnt
);

    typedef enum logic [1:0] {StIdle, StRedirect, StFlush} state_e;

    localparam logic [2:0] FlushLast = (FLUSH_CYCLES == 0) ? 3'd0 : 3'(FLUSH_CYCLES - 1);

    state_e      state_q;
    logic [2:0]  flush_cnt_q;
    logic        accept;
    logic        cond;
    logic        reserved;
    logic        taken;
    logic [31:0] target;

    assign in_ready = (state_q == StIdle) && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        cond     = 1'b0;
        reserved = 1'b0;
        case (funct3)
            3'b000:  cond = zero;
            3'b001:  cond = !zero;
            3'b100:  cond = slt;
            3'b101:  cond = !slt;
            3'b110:  cond = sltu;
            3'b111:  cond = !sltu;
            default: reserved = 1'b1;
        endcase
    end

    // Gating with is_branch keeps unknown flags on non-branches out of the decision.
    assign taken  = is_jal || is_jalr || (is_branch && cond && !reserved);
    assign target = is_jalr ? ((rs1 + imm) & ~32'h1) : (pc + imm);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            flush_cnt_q    <= 3'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            link_pc        <= 32'd0;
            flush          <= 1'b0;
            illegal        <= 1'b0;
            misalign       <= 1'b0;
        end else begin
            illegal  <= 1'b0;
            misalign <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        link_pc <= pc + 32'd4;
                        if (is_branch && reserved) illegal <= 1'b1;
                        if (taken) begin
                            redirect_pc <= target;
                            if (target[1]) begin
                                misalign <= 1'b1;
                            end else begin
                                redirect_valid <= 1'b1;
                                state_q        <= StRedirect;
                            end
                        end
                    end
                end
                StRedirect: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        if (FLUSH_CYCLES == 0) begin
                            state_q <= StIdle;
                        end else begin
                            state_q     <= StFlush;
                            flush       <= 1'b1;
                            flush_cnt_q <= FlushLast;
                        end
                    end
                end
                StFlush: begin
                    if (flush_cnt_q == 3'd0) begin
                        state_q <= StIdle;
                        flush   <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 3'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt <= 32'd0;
            taken_cnt  <= 32'd0;
        end else if (accept) begin
            if (is_branch) branch_cnt <= branch_cnt + 32'd1;
            if (taken && !target[1]) taken_cnt <= taken_cnt + 32'd1;
        end
    end
`else
    assign branch_cnt = 32'd0;
    assign taken_cnt  = 32'd0;
`endif

endmodule

// File: doc/ex_branch_unit.md
# ex_branch_unit

Execute-stage branch resolution unit, directly downstream of the ALU. It consumes the ALU comparison flags (`zero`, `slt`, `sltu`) produced on a `SUB` operation, together with the instruction's branch/jump class, and decides whether control flow changes. On a taken branch or jump it computes the target, holds a redirect request toward fetch until it is accepted, then squashes a fixed number of wrong-path bubbles.

## Interface
- `FLUSH_CYCLES`, default 2: number of cycles `flush` is asserted after a redirect handshake (0 to 7).
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: execute-stage instruction valid.
- `in_ready` out 1: unit can accept an instruction.
- `is_branch` in 1: conditional branch (B-type).
- `is_jal` in 1: JAL.
- `is_jalr` in 1: JALR.
- `funct3` in 3: branch condition select.
- `pc` in 32: instruction PC.
- `imm` in 32: sign-extended immediate.
- `rs1` in 32: rs1 value (JALR base).
- `zero`, `slt`, `sltu` in 1 each: ALU flags; meaningful only when ALU ran `SUB`.
- `redirect_valid` out 1: redirect request to fetch.
- `redirect_ready` in 1: fetch accepts redirect.
- `redirect_pc` out 32: target PC.
- `link_pc` out 32: registered `pc + 4` of last accepted instruction.
- `flush` out 1: squash younger instructions.
- `illegal` out 1: one-cycle pulse, reserved `funct3` on a branch.
- `misalign` out 1: one-cycle pulse, taken target with bit 1 set.
- `branch_cnt`, `taken_cnt` out 32 each: statistics (see Configuration).

## Operation
- States: IDLE, REDIRECT, FLUSH.
- `in_ready` = 1 only in IDLE and not in reset. Accept = `in_valid && in_ready`.
- At most one of `is_branch`/`is_jal`/`is_jalr` is set; none set means a non-control instruction, accepted with no effect except `link_pc` update.
- Flags are ignored unless `is_branch`; X on flags with `is_branch` = 0 must not propagate.
- Condition by `funct3`: 000 BEQ `zero`; 001 BNE `!zero`; 100 BLT `slt`; 101 BGE `!slt`; 110 BLTU `sltu`; 111 BGEU `!sltu`; 010/011 reserved → not taken, pulse `illegal`.
- Target: branch/JAL `pc + imm`; JALR `(rs1 + imm) & ~32'h1`. All 32-bit modulo arithmetic, wrap-around ignored.
- Taken with target[1] = 1: pulse `misalign`, no redirect, stay IDLE.
- Taken and aligned: IDLE → REDIRECT, `redirect_valid` = 1, `redirect_pc` stable until handshake.
- REDIRECT: on `redirect_ready` → FLUSH (or IDLE if `FLUSH_CYCLES` = 0).
- FLUSH: `flush` = 1 for exactly `FLUSH_CYCLES` cycles via down-counter, then IDLE.
- Not taken: remain IDLE, accept next instruction next cycle.

## Timing
- Reset values: state IDLE, `redirect_valid` 0, `redirect_pc` 0, `link_pc` 0, `flush` 0, `illegal` 0, `misalign` 0, counters 0. `rst` in any state aborts the operation; outputs are reset values on the next cycle.
- Decision latency 1: accept at cycle N → `redirect_valid`/`illegal`/`misalign` visible at N+1.
- `redirect_ready` high in the same cycle `redirect_valid` first asserts completes the handshake in that cycle; `flush` high from N+2.
- `redirect_ready` while `redirect_valid` = 0 is ignored.
- Minimum taken-branch occupancy: 2 + `FLUSH_CYCLES` cycles; not-taken: 1 cycle (back-to-back accepts allowed).

## Configuration
- `BRANCH_STATS_EN` defined: `branch_cnt` increments on every accepted `is_branch`; `taken_cnt` increments on every accepted branch/jump that issues a redirect. Both wrap at 2^32 and clear on `rst`.
- Undefined: counters not built; `branch_cnt` and `taken_cnt` tied to 0.

## Test plan
- BEQ, `pc`=0x100, `imm`=0x20, `zero`=1, `redirect_ready`=1 → `redirect_valid` at N+1 with `redirect_pc`=0x120; `flush` high N+2..N+3; `in_ready` back at N+4.
- BLTU, `sltu`=0 → no redirect, `in_ready` stays 1, second instruction accepted at N+1; `link_pc`=`pc+4`.
- JALR, `rs1`=0x2003, `imm`=0x4 → `redirect_pc`=0x2006 → bit1 set → `misalign` pulse, no redirect. With `rs1`=0x2001 → `redirect_pc`=0x2004.
- Redirect with `redirect_ready` low 5 cycles → `redirect_valid`/`redirect_pc` held constant, `in_ready`=0; `flush` starts cycle after ready.
- `funct3`=010 on branch → `illegal` one-cycle pulse, no redirect. Assert `rst` during FLUSH → all outputs reset next cycle, `in_ready`=1.
- With `BRANCH_STATS_EN`: 3 branches (2 taken) + 1 JAL → `branch_cnt`=3, `taken_cnt`=3; without macro both read 0.
